// File: rtl/mux_rr_arbiter.sv
// Purpose : two-requester round-robin arbiter in front of a shared 2:1 mux, with a one-entry output register.
// Latency : an accepted beat appears on o_data the next cycle; arbitration out of IDLE costs one cycle.
// Backpr. : a_ready/b_ready drop while the output register is full and o_ready is low; buffered beat held stable.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   a_valid/a_data/a_ready   requester A (valid/ready)
//   b_valid/b_data/b_ready   requester B (valid/ready)
//   o_valid/o_data/o_ready   registered output towards the consumer
//   s                  mux select / current-or-last grant (0 = A, 1 = B)
module mux_rr_arbiter #(
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a_valid,
    input  logic [WIDTH-1:0] a_data,
    output logic             a_ready,
    input  logic             b_valid,
    input  logic [WIDTH-1:0] b_data,
    output logic             b_ready,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    input  logic             o_ready,
    output logic             s
);

    localparam int CW = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] BURST_END = CW'(MAX_BURST);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_A = 2'd1,
        GNT_B = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt, cnt_inc;
    logic          last, last_nxt;   // 0 = A served last, 1 = B served last
    logic          s_nxt;
    logic          pipe_ok;
    logic          own_valid, oth_valid, own_acc;
    state_t        other_gnt;

    // Output register can take a new beat when empty or draining this cycle.
    assign pipe_ok = !o_valid || o_ready;

    assign a_ready = (state == GNT_A) && pipe_ok;
    assign b_ready = (state == GNT_B) && pipe_ok;

    // "Own" is the current grant holder, "other" the competing side.
    assign own_valid = (state == GNT_B) ? b_valid : a_valid;
    assign oth_valid = (state == GNT_B) ? a_valid : b_valid;
    assign other_gnt = (state == GNT_B) ? GNT_A : GNT_B;
    assign own_acc   = (state != IDLE) && own_valid && pipe_ok;
    assign cnt_inc   = cnt + CW'(1);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        last_nxt  = last;
        case (state)
            IDLE: begin
                if (a_valid && b_valid) begin
                    // Tie: the side not served last wins.
                    state_nxt = last ? GNT_A : GNT_B;
                end else if (a_valid) begin
                    state_nxt = GNT_A;
                end else if (b_valid) begin
                    state_nxt = GNT_B;
                end
            end
            GNT_A, GNT_B: begin
                if (own_valid) begin
                    if (pipe_ok) begin
                        last_nxt = (state == GNT_B);
                        if (cnt_inc == BURST_END) begin
                            // Burst budget used up: hand over only if the other side waits.
                            cnt_nxt = '0;
                            if (oth_valid) begin
                                state_nxt = other_gnt;
                            end
                        end else begin
                            cnt_nxt = cnt_inc;
                        end
                    end
                end else begin
                    // Owner went quiet: switch directly if the other side waits, no IDLE bubble.
                    cnt_nxt   = '0;
                    state_nxt = oth_valid ? other_gnt : IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Select tracks the grant and keeps its last value while idle.
    always_comb begin
        s_nxt = s;
        if (state_nxt == GNT_A) begin
            s_nxt = 1'b0;
        end else if (state_nxt == GNT_B) begin
            s_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            last  <= 1'b1;
            s     <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            last  <= last_nxt;
            s     <= s_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_valid <= 1'b0;
            o_data  <= '0;
        end else if (own_acc) begin
            o_valid <= 1'b1;
            o_data  <= (state == GNT_B) ? b_data : a_data;
        end else if (o_ready) begin
            o_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
module tb_mux_rr_arbiter;

    logic       clk;
    logic       rst_n;
    logic       a_valid, b_valid, o_ready;
    logic [7:0] a_data, b_data;
    logic       a_ready, b_ready, o_valid, s;
    logic [7:0] o_data;

    logic       a1_valid, b1_valid, o1_ready;
    logic [7:0] a1_data, b1_data;
    logic       a1_ready, b1_ready, o1_valid, s1;
    logic [7:0] o1_data;

    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] sb_q[$];
    logic [7:0] sb1_q[$];
    logic       gap_arm = 1'b0;
    logic       seen_first = 1'b0;
    int         gap_cnt = 0;
    logic       acc_a, acc_b;
    int         n_out;

    mux_rr_arbiter #(.WIDTH(8), .MAX_BURST(4)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
        .o_valid(o_valid), .o_data(o_data), .o_ready(o_ready),
        .s(s)
    );

    mux_rr_arbiter #(.WIDTH(8), .MAX_BURST(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a1_valid), .a_data(a1_data), .a_ready(a1_ready),
        .b_valid(b1_valid), .b_data(b1_data), .b_ready(b1_ready),
        .o_valid(o1_valid), .o_data(o1_data), .o_ready(o1_ready),
        .s(s1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Output monitor: pops the scoreboard on every transfer and checks grant exclusivity.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("ready_excl", 32'(a_ready && b_ready), 32'd0);
            if (gap_arm && seen_first && sb_q.size() > 0 && !o_valid) gap_cnt++;
            if (o_valid && o_ready) begin
                if (sb_q.size() == 0) chk("sb_extra_beat", 32'(o_data), 32'hFFFF);
                else chk("sb_data", 32'(o_data), 32'(sb_q.pop_front()));
                seen_first = 1'b1;
            end
        end
    end

    task automatic drive_a(input int n, input logic [7:0] base);
        for (int i = 0; i < n; i++) begin
            int t;
            t = 0;
            a_valid = 1'b1;
            a_data  = base + 8'(i);
            @(negedge clk);
            while (!a_ready && t < 100) begin
                @(negedge clk);
                t++;
            end
            if (!a_ready) begin
                chk("a_accept_timeout", 32'd0, 32'd1);
                break;
            end
            chk("s_on_a_accept", 32'(s), 32'd0);
            @(posedge clk);
            #1;
        end
        a_valid = 1'b0;
    endtask

    task automatic drive_b(input int n, input logic [7:0] base);
        for (int i = 0; i < n; i++) begin
            int t;
            t = 0;
            b_valid = 1'b1;
            b_data  = base + 8'(i);
            @(negedge clk);
            while (!b_ready && t < 100) begin
                @(negedge clk);
                t++;
            end
            if (!b_ready) begin
                chk("b_accept_timeout", 32'd0, 32'd1);
                break;
            end
            chk("s_on_b_accept", 32'(s), 32'd1);
            @(posedge clk);
            #1;
        end
        b_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int t;
        t = 0;
        while (sb_q.size() != 0 && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk(tag, 32'(sb_q.size()), 32'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        a_valid = 0; b_valid = 0; a_data = 0; b_data = 0; o_ready = 1;
        a1_valid = 0; b1_valid = 0; a1_data = 0; b1_data = 0; o1_ready = 1;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_o_valid", 32'(o_valid), 32'd0);
        chk("rst_o_data", 32'(o_data), 32'd0);
        chk("rst_a_ready", 32'(a_ready), 32'd0);
        chk("rst_b_ready", 32'(b_ready), 32'd0);
        chk("rst_s", 32'(s), 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // A only: ready one cycle after valid, grant kept past the burst limit.
        for (int i = 0; i < 6; i++) sb_q.push_back(8'h11 + 8'(i));
        a_valid = 1'b1;
        a_data  = 8'h11;
        @(negedge clk);
        chk("a_ready_lat0", 32'(a_ready), 32'd0);
        @(negedge clk);
        chk("a_ready_lat1", 32'(a_ready), 32'd1);
        @(posedge clk);
        #1;
        drive_a(5, 8'h12);
        drain("drain_a_only");

        // Both valid after an A burst: B first, 4-beat alternation, no output bubble.
        for (int i = 0; i < 4; i++) sb_q.push_back(8'h40 + 8'(i));
        for (int i = 0; i < 4; i++) sb_q.push_back(8'h30 + 8'(i));
        for (int i = 0; i < 4; i++) sb_q.push_back(8'h44 + 8'(i));
        for (int i = 0; i < 4; i++) sb_q.push_back(8'h34 + 8'(i));
        gap_arm = 1'b1; seen_first = 1'b0; gap_cnt = 0;
        fork
            drive_a(8, 8'h30);
            drive_b(8, 8'h40);
        join
        drain("drain_both");
        gap_arm = 1'b0;
        chk("no_bubble", 32'(gap_cnt), 32'd0);

        // B burst then a tie: A wins.
        sb_q.push_back(8'h50); sb_q.push_back(8'h51);
        drive_b(2, 8'h50);
        drain("drain_b_only");
        sb_q.push_back(8'h60); sb_q.push_back(8'h70);
        fork
            drive_a(1, 8'h60);
            drive_b(1, 8'h70);
        join
        drain("drain_tie_after_b");

        // Backpressure: hold 0x22 for three cycles, nothing lost or duplicated.
        for (int i = 0; i < 4; i++) sb_q.push_back(8'h20 + 8'(i));
        fork
            drive_a(4, 8'h20);
            begin
                int t;
                t = 0;
                @(negedge clk);
                while (!(a_valid && a_ready && a_data == 8'h22) && t < 100) begin
                    @(negedge clk);
                    t++;
                end
                @(posedge clk);
                #1 o_ready = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    chk("bp_hold_data", 32'(o_data), 32'h22);
                    chk("bp_a_ready", 32'(a_ready), 32'd0);
                    chk("bp_o_valid", 32'(o_valid), 32'd1);
                end
                @(posedge clk);
                #1 o_ready = 1'b1;
            end
        join
        drain("drain_bp");

        // Early drop by A after 2 beats: B takes over and gets a full burst while A waits.
        sb_q.push_back(8'h80); sb_q.push_back(8'h81);
        for (int i = 0; i < 4; i++) sb_q.push_back(8'h90 + 8'(i));
        sb_q.push_back(8'h88); sb_q.push_back(8'h89); sb_q.push_back(8'h94);
        fork
            begin
                drive_a(2, 8'h80);
                @(posedge clk);
                #1;
                drive_a(2, 8'h88);
            end
            begin
                repeat (2) @(posedge clk);
                #1;
                drive_b(5, 8'h90);
            end
        join
        drain("drain_early_drop");

        // Reset in GNT_B with a buffered beat: discarded immediately.
        o_ready = 1'b0;
        b_valid = 1'b1;
        b_data  = 8'hB0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("pre_rst_s", 32'(s), 32'd1);
        chk("pre_rst_o_valid", 32'(o_valid), 32'd1);
        chk("pre_rst_o_data", 32'(o_data), 32'hB0);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_o_valid", 32'(o_valid), 32'd0);
        chk("mid_rst_o_data", 32'(o_data), 32'd0);
        chk("mid_rst_a_ready", 32'(a_ready), 32'd0);
        chk("mid_rst_b_ready", 32'(b_ready), 32'd0);
        chk("mid_rst_s", 32'(s), 32'd0);
        b_valid = 1'b0;
        o_ready = 1'b1;
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        sb_q.push_back(8'hC0); sb_q.push_back(8'hD0);
        fork
            drive_a(1, 8'hC0);
            drive_b(1, 8'hD0);
        join
        drain("drain_tie_after_rst");

        // MAX_BURST=1 instance: strict per-beat alternation starting with A.
        for (int i = 0; i < 4; i++) begin
            sb1_q.push_back(8'hA0 + 8'(i));
            sb1_q.push_back(8'hB0 + 8'(i));
        end
        a1_valid = 1'b1; b1_valid = 1'b1; a1_data = 8'hA0; b1_data = 8'hB0;
        n_out = 0;
        for (int t = 0; t < 40 && n_out < 8; t++) begin
            @(negedge clk);
            acc_a = a1_valid && a1_ready;
            acc_b = b1_valid && b1_ready;
            if (o1_valid && o1_ready) begin
                chk("mb1_data", 32'(o1_data), 32'(sb1_q.pop_front()));
                n_out++;
            end
            @(posedge clk);
            #1;
            if (acc_a) a1_data = a1_data + 8'd1;
            if (acc_b) b1_data = b1_data + 8'd1;
        end
        chk("mb1_count", 32'(n_out), 32'd8);
        a1_valid = 1'b0;
        b1_valid = 1'b0;
        repeat (2) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mux_rr_arbiter.md
Name: mux_rr_arbiter

Overview:
- Shares one 2:1 mux datapath (select `s`, output `o`) between two valid/ready requesters, A and B.
- A round-robin FSM picks the owner and drives `s`. The selected beat is captured in a one-entry output register.
- The arbiter holds a grant for a burst and forces a switch after MAX_BURST beats when the other side is waiting.
- Sits between two data producers and a single downstream consumer.

Parameters:
- WIDTH, 8, data width of a_data/b_data/o_data.
- MAX_BURST, 4, max beats per grant while the other requester is waiting; legal values >= 1.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- a_valid  input  1  requester A has a beat.
- a_data  input  WIDTH  requester A payload.
- a_ready  output  1  A beat accepted this cycle when a_valid && a_ready.
- b_valid  input  1  requester B has a beat.
- b_data  input  WIDTH  requester B payload.
- b_ready  output  1  B beat accepted this cycle when b_valid && b_ready.
- o_valid  output  1  output register holds a beat.
- o_data  output  WIDTH  registered mux output.
- o_ready  input  1  downstream accepts the beat when o_valid && o_ready.
- s  output  1  current/last grant: 0 = A, 1 = B (mux select).

Behaviour:
- Single clock domain, clk only; rst_n asynchronous active-low.
- Reset values, applied immediately on assertion, including mid-burst:
  - state=IDLE, s=0, last=B (so A wins the first tie), cnt=0.
  - o_valid=0, o_data=0, a_ready=b_ready=0.
  - Any buffered beat is discarded.
- FSM states: IDLE, GNT_A, GNT_B. s is registered: 0 in GNT_A, 1 in GNT_B; holds its last value in IDLE.
- pipe_ok = !o_valid || o_ready.
- Ready outputs are combinational:
  - a_ready = (state==GNT_A) && pipe_ok.
  - b_ready = (state==GNT_B) && pipe_ok.
  - Never both high; both low in IDLE.
- IDLE transitions:
  - Only a_valid -> GNT_A.
  - Only b_valid -> GNT_B.
  - Both valid -> grant the side not equal to last.
  - Neither valid -> stay in IDLE.
  - Arbitration latency is 1 cycle: a request seen in IDLE gets ready no earlier than the next cycle.
- GNT_X, where X is the owner and Y the other side:
  - X_valid && X_ready: beat accepted. o_data <= X_data, o_valid <= 1, cnt <= cnt+1, last <= X.
    - If cnt+1 == MAX_BURST and Y_valid: go to GNT_Y, cnt <= 0.
    - If cnt+1 == MAX_BURST and !Y_valid: stay in GNT_X, cnt <= 0.
  - X_valid && !pipe_ok (stall): hold state, cnt and o_data.
  - !X_valid: leave the grant.
    - If Y_valid -> GNT_Y directly, no IDLE bubble.
    - Else -> IDLE.
    - cnt <= 0 in both cases.
- Output register:
  - o_valid && o_ready with no new beat loaded -> o_valid <= 0.
  - o_ready and a new beat in the same cycle -> new beat loads, o_valid stays 1.
  - o_data is stable while o_valid && !o_ready.
- Latency: accepted beat appears on o_data the next cycle. Throughput is 1 beat/cycle with o_ready held high.
- cnt width: clog2(MAX_BURST+1). cnt never exceeds MAX_BURST-1 between accepted beats.
- MAX_BURST=1 with both requesters continuously valid: strict per-beat alternation A,B,A,B.
- The grant switch itself costs no cycle:
  - The first beat of the new owner can be accepted in the cycle after the last beat of the old owner.
  - o_valid stays continuously 1 across the switch.
- Requesters keep X_valid and X_data stable until accepted. Behaviour if they violate this is undefined; no checking is done.
- No beat is lost or duplicated under any o_ready pattern.

Test Plan:
- Reset mid-burst: in GNT_B with o_valid=1, drop rst_n asynchronously -> o_valid=0, o_data=0, a_ready=b_ready=0, s=0 before the next clk edge. After release, the first tie grants A.
- A only, o_ready=1, a_data 0x11..0x16 -> a_ready rises 1 cycle after a_valid. o_data=0x11..0x16 on consecutive cycles, each one cycle after acceptance. s=0 throughout; grant retained past 4 beats.
- Both continuously valid, MAX_BURST=4, o_ready=1 -> output order A,A,A,A,B,B,B,B,A... s toggles every 4 beats; o_valid never drops; a_ready&&b_ready never high together.
- Backpressure: o_ready=0 for 3 cycles while o_valid=1, o_data=0x22 -> o_data holds 0x22, a_ready=0, cnt unchanged. When o_ready=1, the next A beat follows with no loss or duplication.
- Early drop: in GNT_A after 2 beats, a_valid=0 while b_valid=1 -> GNT_B next cycle, s=1, B gets a full 4-beat burst (cnt reset).
- Tie in IDLE after a B burst with last=B -> A granted. Repeat after an A burst -> B granted. With MAX_BURST=1, the outputs alternate A,B per beat.
